fwft_split_reader: RTL and testbench

//  Single-clock drain engine at the read end of a wide FWFT FIFO.
//  - Pops one wide word and emits it as 2**WIDTH_RATIO_LOG2 narrow beats on a valid/ready stream.
//  - Beat order is LSB lane first.
//  - Inverse of the narrow-write/wide-read concat path: lets a concat FIFO feed a narrow consumer.
//  - Sustains one narrow beat per clock with no inter-word bubble.

---
 rtl/fifo_width_pkg.sv | 20 ++
 rtl/fwft_split_reader.sv | 84 ++++++++
 tb/tb_fwft_split_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fifo_width_pkg.sv
// Shared types and lane helper for the wide/narrow FIFO width adapters.
// lane_select works on a word zero-extended to LANE_MAX_W so that every adapter can share it.
package fifo_width_pkg;

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam int unsigned LANE_MAX_W = 512;

  function automatic logic [LANE_MAX_W-1:0] lane_select(
    input logic [LANE_MAX_W-1:0] word,
    input int unsigned           idx,
    input int unsigned           lane_w
  );
    logic [LANE_MAX_W-1:0] mask;
    if (lane_w >= LANE_MAX_W) mask = '1;
    else                      mask = (LANE_MAX_W'(1) << lane_w) - LANE_MAX_W'(1);
    return (word >> (idx * lane_w)) & mask;
  endfunction

endpackage

// File: rtl/fwft_split_reader.sv
// Drains a wide FWFT FIFO word by word and replays each word as 2**WIDTH_RATIO_LOG2
// narrow valid/ready beats, LSB lane first, with no bubble between words.
module fwft_split_reader
  import fifo_width_pkg::*;
#(
  parameter  int unsigned RD_WIDTH_BYTES   = 4,
  parameter  int unsigned WIDTH_RATIO_LOG2 = 2,
  localparam int unsigned IN_WIDTH         = 8 * RD_WIDTH_BYTES,
  localparam int unsigned OUT_WIDTH        = IN_WIDTH >> WIDTH_RATIO_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_first,
  output logic                 out_last,
  input  logic                 flush,
  output logic                 busy
);

  localparam int unsigned RATIO  = 1 << WIDTH_RATIO_LOG2;
  // A ratio of 1 still needs a 1-bit counter; it simply never leaves zero.
  localparam int unsigned LANE_W = (WIDTH_RATIO_LOG2 > 0) ? WIDTH_RATIO_LOG2 : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if ((OUT_WIDTH * RATIO != IN_WIDTH) || (OUT_WIDTH < 8) || (IN_WIDTH > LANE_MAX_W)) begin : g_param_err
    $error("fwft_split_reader: illegal width parameters");
  end

  state_e              r_state, w_state_nxt;
  logic [IN_WIDTH-1:0] r_hold,  w_hold_nxt;
  logic [LANE_W-1:0]   r_lane,  w_lane_nxt;

  logic w_active, w_beat_xfer, w_last_xfer, w_pop;

  assign w_active    = (r_state == ACTIVE);
  assign w_beat_xfer = w_active & out_ready;
  assign w_last_xfer = w_beat_xfer & (r_lane == LAST_LANE);
  // Reloading on the last accepted beat is what keeps consecutive words gap-free.
  assign w_pop       = !rst & !fifo_empty & !flush & (!w_active | w_last_xfer);

  assign fifo_rd_en = w_pop;
  assign out_valid  = w_active;
  assign busy       = w_active;
  assign out_first  = w_active & (r_lane == '0);
  assign out_last   = w_active & (r_lane == LAST_LANE);
  assign out_data   = OUT_WIDTH'(lane_select(LANE_MAX_W'(r_hold), int'(r_lane), OUT_WIDTH));

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_lane_nxt  = r_lane;
    if (flush) begin
      // Held word is dropped; a beat accepted this cycle has already left.
      w_state_nxt = IDLE;
      w_lane_nxt  = '0;
    end else if (w_pop) begin
      w_state_nxt = ACTIVE;
      w_hold_nxt  = fifo_rd_data;
      w_lane_nxt  = '0;
    end else if (w_last_xfer) begin
      w_state_nxt = IDLE;
    end else if (w_beat_xfer) begin
      w_lane_nxt  = r_lane + LANE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

endmodule

// File: tb/tb_fwft_split_reader.sv
// Scoreboard bench: the driver feeds a word queue and random handshakes; the monitor
// expands each popped word into its expected byte beats and compares what the DUT shows.
module tb_fwft_split_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_rd_en, out_valid, out_first, out_last, busy;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  fwft_split_reader #(.RD_WIDTH_BYTES(4), .WIDTH_RATIO_LOG2(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .flush(flush), .busy(busy)
  );

  typedef struct packed { logic [7:0] d; logic f; logic l; } beat_t;

  beat_t       exp_q[$];
  logic [31:0] src_q[$];
  int          checks = 0, errors = 0, delivered = 0;
  int          gap_pct = 0, flush_pct = 0;
  bit          rand_ready = 1'b0;
  logic        ready_f = 1'b1, flush_f = 1'b0, rst_f = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs after the driver has settled this cycle's inputs, before the next posedge.
  always @(negedge clk) begin
    bit exp_rd;
    logic [31:0] w;
    #1;
    if (rst) begin
      chk("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
      exp_q.delete();
    end else begin
      exp_rd = !fifo_empty && !flush &&
               (exp_q.size() == 0 || (out_ready && exp_q.size() == 1));
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
        chk("out_first", {31'd0, out_first}, {31'd0, exp_q[0].f});
        chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end else begin
        chk("idle_first_last", {30'd0, out_first, out_last}, 32'd0);
      end
      chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
      if (flush) exp_q.delete();
      if (exp_rd && src_q.size() != 0) begin
        w = src_q.pop_front();
        for (int i = 0; i < 4; i++)
          exp_q.push_back('{d: 8'((w >> (8 * i)) & 32'hFF), f: (i == 0), l: (i == 3)});
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    rst          = rst_f;
    fifo_empty   = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
    fifo_rd_data = (src_q.size() != 0) ? src_q[0] : $urandom();
    out_ready    = rand_ready ? 1'($urandom_range(1)) : ready_f;
    flush        = flush_f || ($urandom_range(99) < flush_pct);
    #2;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    if (src_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles (src=%0d beats=%0d)",
               name, limit, src_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_delivered(input string name, input int target, input int limit);
    int n = 0;
    while (delivered < target && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    if (delivered < target) begin
      errors++;
      $display("FAIL %s: delivered %0d expected %0d", name, delivered, target);
    end
  endtask

  int bp[6] = '{1, 0, 0, 1, 1, 1};

  initial begin
    rst_f = 1'b1; ready_f = 1'b1;
    repeat (3) cycle();
    rst_f = 1'b0;
    repeat (2) cycle();

    src_q.push_back(32'hDEADBEEF);
    wait_drain("single_word", 20);

    src_q.push_back(32'h01020304);
    src_q.push_back(32'h05060708);
    wait_drain("back_to_back", 20);

    src_q.push_back(32'hA3A2A1A0);
    cycle();
    foreach (bp[i]) begin
      ready_f = bp[i][0];
      cycle();
    end
    ready_f = 1'b1;
    wait_drain("backpressure", 20);

    repeat (50) cycle();
    src_q.push_back(32'h0BADF00D);
    wait_drain("after_empty", 20);

    src_q.push_back(32'h11223344);
    src_q.push_back(32'h55667788);
    wait_delivered("flush_pre", delivered + 2, 20);
    flush_f = 1'b1; ready_f = 1'b0;
    cycle();
    flush_f = 1'b0; ready_f = 1'b1;
    wait_drain("flush", 20);

    src_q.push_back(32'hCAFEF00D);
    wait_delivered("reset_pre", delivered + 1, 20);
    rst_f = 1'b1; ready_f = 1'b0;
    cycle();
    rst_f = 1'b0; ready_f = 1'b1;
    src_q.push_back(32'h76543210);
    wait_drain("reset_mid_word", 20);

    rand_ready = 1'b1; gap_pct = 20; flush_pct = 4;
    for (int c = 0; c < 600; c++) begin
      if (src_q.size() < 4 && $urandom_range(99) < 40) src_q.push_back($urandom());
      cycle();
    end
    flush_pct = 0;
    wait_drain("random", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
